mlt_issue_q: RTL and testbench



---
 rtl/mlt_issue_pkg.sv | 23 ++
 rtl/mlt_issue_q_fifo_sync.sv | 58 +++++
 rtl/mlt_issue_q.sv | 118 +++++++++++
 tb/tb_mlt_issue_q.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mlt_issue_pkg.sv
// Shared types for the multiply issue queue: command/response records and FSM state.
package mlt_issue_pkg;

  localparam int MLT_W     = 32;
  localparam int MLT_TAG_W = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [MLT_W-1:0]     a;
    logic [MLT_W-1:0]     b;
    logic [MLT_TAG_W-1:0] tag;
  } mlt_issue_cmd_t;

  typedef struct packed {
    logic [2*MLT_W-1:0]   y;
    logic [MLT_TAG_W-1:0] tag;
  } mlt_issue_rsp_t;

endpackage

// File: rtl/mlt_issue_q_fifo_sync.sv
// Synchronous FIFO with registered non-empty flag, occupancy count and
// combinational head read.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             nempty_r,
  output logic [CW-1:0]    cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      nempty_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt      <= cnt_nxt;
      nempty_r <= (cnt_nxt != '0);
    end
  end

  // Storage is not reset; occupancy tracking alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && cnt == CW'(DEPTH)));

endmodule

// File: rtl/mlt_issue_q.sv
// Command queue, one-at-a-time issue to a non-stallable 4-cycle multiplier,
// and a credit-protected response queue.
module mlt_issue_q
  import mlt_issue_pkg::*;
#(
  parameter int W         = MLT_W,
  parameter int TAG_W     = MLT_TAG_W,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_vld,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             cmd_rdy,
  output logic             rsp_vld_r,
  output logic [2*W-1:0]   rsp_y,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             rsp_rdy,
  output logic [W-1:0]     mult_a,
  output logic [W-1:0]     mult_b,
  output logic             mult_pass,
  input  logic [2*W-1:0]   mult_y,
  input  logic             mult_y_vld,
  input  logic             mult_busy,
  output logic             idle_r
);

  // state  | meaning
  // S_IDLE | nothing in flight in the multiplier
  // S_BUSY | one operation in flight, result expected on mult_y_vld

  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;

  if (W != MLT_W || TAG_W != MLT_TAG_W) begin : g_param_chk
    $error("mlt_issue_q: W/TAG_W must match mlt_issue_pkg record widths");
  end

  state_t          state;
  mlt_issue_cmd_t  cmd_in, cmd_head;
  mlt_issue_rsp_t  rsp_in, rsp_head;
  logic [CMD_CW-1:0] cmd_cnt;
  logic [RSP_CW-1:0] rsp_cnt;
  logic            cmd_nempty;
  logic [W-1:0]    op_a_r, op_b_r;
  logic [TAG_W-1:0] op_tag_r;
  logic            cmd_push, rsp_push, rsp_pop, credit, issue;

  assign cmd_in   = '{a: cmd_a, b: cmd_b, tag: cmd_tag};
  assign cmd_rdy  = (cmd_cnt != CMD_CW'(CMD_DEPTH));
  assign cmd_push = cmd_vld && cmd_rdy;

  fifo_sync #(.WIDTH($bits(mlt_issue_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_q (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_push),
    .din      (cmd_in),
    .pop      (issue),
    .dout     (cmd_head),
    .nempty_r (cmd_nempty),
    .cnt      (cmd_cnt)
  );

  // Credit counts the in-flight op against response space; a pop in this
  // same cycle is deliberately not credited.
  assign credit = (int'(rsp_cnt) + int'(state == S_BUSY)) < RSP_DEPTH;
  assign issue  = !mult_busy && cmd_nempty && credit &&
                  (state == S_IDLE || mult_y_vld);

  assign mult_pass = issue;
  assign mult_a    = issue ? cmd_head.a : op_a_r;
  assign mult_b    = issue ? cmd_head.b : op_b_r;

  assign rsp_push = (state == S_BUSY) && mult_y_vld;
  assign rsp_pop  = rsp_vld_r && rsp_rdy;
  assign rsp_in   = '{y: mult_y, tag: op_tag_r};

  fifo_sync #(.WIDTH($bits(mlt_issue_rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_q (
    .clk      (clk),
    .rst      (rst),
    .push     (rsp_push),
    .din      (rsp_in),
    .pop      (rsp_pop),
    .dout     (rsp_head),
    .nempty_r (rsp_vld_r),
    .cnt      (rsp_cnt)
  );

  assign rsp_y   = rsp_head.y;
  assign rsp_tag = rsp_head.tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_a_r   <= '0;
      op_b_r   <= '0;
      op_tag_r <= '0;
    end else begin
      if (issue) begin
        op_a_r   <= cmd_head.a;
        op_b_r   <= cmd_head.b;
        op_tag_r <= cmd_head.tag;
        state    <= S_BUSY;
      end else if (rsp_push) begin
        state    <= S_IDLE;
      end
    end
  end

  assign idle_r = (state == S_IDLE) && (cmd_cnt == '0) && (rsp_cnt == '0);

  a_no_stray_result: assert property (@(posedge clk) disable iff (rst)
    !(mult_y_vld && state == S_IDLE));

endmodule

// File: tb/tb_mlt_issue_q.sv
// Scoreboard bench for mlt_issue_q with a behavioural 4-cycle multiplier model.
module tb_mlt_issue_q;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_vld = 1'b0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic [3:0]  cmd_tag = '0;
  logic        cmd_rdy, rsp_vld_r, rsp_rdy = 1'b1;
  logic [63:0] rsp_y;
  logic [3:0]  rsp_tag;
  logic [31:0] mult_a, mult_b;
  logic        mult_pass, mult_y_vld, mult_busy, idle_r;
  logic [63:0] mult_y;

  int checks = 0, failures = 0, cyc = 0, rsp_count = 0, last_rsp_cyc = -1;
  int pass_cycles[$];
  logic [67:0] exp_q[$];
  bit rnd_mode = 1'b0;

  mlt_issue_q dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_tag(cmd_tag), .cmd_rdy(cmd_rdy), .rsp_vld_r(rsp_vld_r), .rsp_y(rsp_y),
    .rsp_tag(rsp_tag), .rsp_rdy(rsp_rdy), .mult_a(mult_a), .mult_b(mult_b),
    .mult_pass(mult_pass), .mult_y(mult_y), .mult_y_vld(mult_y_vld),
    .mult_busy(mult_busy), .idle_r(idle_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier: pass in C0, busy C1..C4, result pulse in the next cycle.
  int          m_cnt = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [63:0] m_y = '0;
  assign mult_busy  = (m_cnt >= 2);
  assign mult_y_vld = (m_cnt == 1);
  assign mult_y     = m_y;

  always @(posedge clk) begin
    if (rst) m_cnt <= 0;
    else if (mult_pass && !mult_busy) begin
      m_cnt <= 5; m_a <= mult_a; m_b <= mult_b;
    end else if (m_cnt > 0) m_cnt <= m_cnt - 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++; failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor and multiplier-side checks, sampled mid-cycle.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (mult_pass) begin
        pass_cycles.push_back(cyc);
        if (mult_busy) check("pass_while_busy", 1'b1, 1'b0);
      end
      if (m_cnt >= 3 && m_cnt <= 5) begin
        check("hold_a", mult_a, m_a);
        check("hold_b", mult_b, m_b);
      end
      if (m_cnt == 3) m_y = 64'(mult_a) * 64'(mult_b);
      if (rsp_vld_r && rsp_rdy) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected actual=%0h required=none", rsp_y);
        end else begin
          logic [67:0] e;
          e = exp_q.pop_front();
          check("rsp_y", rsp_y, e[67:4]);
          check("rsp_tag", 64'(rsp_tag), 64'(e[3:0]));
        end
        rsp_count++;
        last_rsp_cyc = cyc;
      end
    end
  end

  always @(negedge clk) if (rnd_mode) rsp_rdy = 1'($urandom_range(0, 1));

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, output int acc);
    acc = -1;
    cmd_vld = 1'b1; cmd_a = a; cmd_b = b; cmd_tag = tag;
    for (int i = 0; i < 400 && acc < 0; i++) begin
      if (cmd_rdy) begin
        acc = cyc;
        exp_q.push_back({64'(a) * 64'(b), tag});
      end
      @(negedge clk);
    end
    cmd_vld = 1'b0; cmd_a = $urandom; cmd_b = $urandom; cmd_tag = 4'($urandom);
    if (acc < 0) fail_now("send_timeout");
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_count < target && n < 600) begin
      @(negedge clk); #2; n++;
    end
    if (rsp_count < target) fail_now("wait_rsp");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(idle_r && exp_q.size() == 0) && n < 800) begin
      @(negedge clk); #2; n++;
    end
    if (!(idle_r && exp_q.size() == 0)) fail_now("wait_idle");
    @(negedge clk);
  endtask

  initial begin
    int acc, acc1, base, r;
    int accs[5];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_rdy", cmd_rdy, 1'b1);
    check("rst_rsp_vld", rsp_vld_r, 1'b0);
    check("rst_pass", mult_pass, 1'b0);
    check("rst_mult_a", mult_a, 32'd0);
    check("rst_mult_b", mult_b, 32'd0);
    check("rst_idle", idle_r, 1'b1);
    @(negedge clk);

    // Single command latency
    pass_cycles.delete();
    rsp_rdy = 1'b1;
    send(32'd3, 32'd5, 4'd2, acc);
    wait_rsp(rsp_count + 1);
    check("single_pass_cyc", 64'(pass_cycles[0]), 64'(acc + 1));
    check("single_rsp_cyc", 64'(last_rsp_cyc), 64'(acc + 7));
    check("single_idle_low", idle_r, 1'b0);
    @(negedge clk);
    check("single_idle_back", idle_r, 1'b1);
    wait_idle();

    // Burst of 4: one issue every 5 cycles
    pass_cycles.delete();
    base = rsp_count;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, acc1);
    send(32'd7, 32'd6, 4'd3, acc);
    send($urandom, $urandom, 4'd9, acc);
    send($urandom, $urandom, 4'd9, acc);
    wait_rsp(base + 4);
    if (pass_cycles.size() != 4) check("burst_passes", 64'(pass_cycles.size()), 64'd4);
    else begin
      check("burst_first_pass", 64'(pass_cycles[0]), 64'(acc1 + 1));
      for (int i = 1; i < 4; i++)
        check("burst_spacing", 64'(pass_cycles[i] - pass_cycles[i-1]), 64'd5);
    end
    wait_idle();

    // Response back-pressure: credit stalls issue after two results
    pass_cycles.delete();
    base = rsp_count;
    rsp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom, $urandom, 4'(i + 4), acc);
    repeat (40) @(negedge clk);
    check("bp_passes", 64'(pass_cycles.size()), 64'd2);
    check("bp_rsp_vld", rsp_vld_r, 1'b1);
    check("bp_no_pop", 64'(rsp_count), 64'(base));
    rsp_rdy = 1'b1;
    r = cyc;
    wait_rsp(base + 4);
    if (pass_cycles.size() < 3) check("bp_resume_count", 64'(pass_cycles.size()), 64'd3);
    else check("bp_resume_cyc", 64'(pass_cycles[2]), 64'(r + 1));
    wait_idle();

    // Five back-to-back pushes fill the command queue
    base = rsp_count;
    for (int i = 0; i < 5; i++) send($urandom, $urandom, 4'(i), accs[i]);
    check("full_cmd_rdy", cmd_rdy, 1'b0);
    check("full_acc_span", 64'(accs[4] - accs[0]), 64'd4);
    wait_rsp(base + 5);
    wait_idle();

    // Operand bus churn while busy
    base = rsp_count;
    send(32'h1234_5678, 32'h0000_ABCD, 4'd7, acc);
    for (int i = 0; i < 8; i++) begin
      cmd_a = $urandom; cmd_b = $urandom; @(negedge clk);
    end
    wait_rsp(base + 1);
    wait_idle();

    // Reset two cycles after pass drops the in-flight op
    pass_cycles.delete();
    base = rsp_count;
    send(32'd11, 32'd13, 4'd5, acc);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_rsp_vld", rsp_vld_r, 1'b0);
    check("rst_mid_idle", idle_r, 1'b1);
    repeat (10) @(negedge clk);
    check("rst_mid_no_rsp", 64'(rsp_count), 64'(base));
    send(32'd21, 32'd2, 4'd6, acc);
    wait_rsp(base + 1);
    wait_idle();

    // Randomised traffic with random consumer stalls
    base = rsp_count;
    rnd_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send($urandom, $urandom, 4'($urandom), acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_rsp(base + 10);
    rnd_mode = 1'b0;
    rsp_rdy = 1'b1;
    wait_rsp(base + 24);
    wait_idle();
    check("rnd_drained", 64'(rsp_count - base), 64'd24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
